max_index_scan: RTL and testbench

MAX_INDEX_SCAN -- requirements
Module: max_index_scan

---
 rtl/max_index_scan.sv | 118 +++++++++++
 tb/tb_max_index_scan.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_index_scan.sv
`default_nettype none
// ============================================================================
// Module   : max_index_scan
// Brief    : Frame-based arg-max scanner. Accepts a stream of (metric, index)
//            beats, tracks the strictly-greatest metric of each frame (ties
//            keep the earlier beat) and holds the winner until consumed.
//            Frames close on in_last or when MAX_LEN beats have arrived; the
//            latter case is flagged with out_trunc.
//            Optional build macro: MAX_INDEX_SCAN_SIGNED_EN selects a
//            two's-complement comparison instead of the default unsigned one.
// Revision : 1.0 - initial release
// ============================================================================
module max_index_scan #(
    parameter int P_SIZE      = 32,
    parameter int POS_NUM_BIT = 4,
    parameter int MAX_LEN     = 16,
    parameter int CNT_BITS    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [P_SIZE-1:0]      in_data,
    input  logic [POS_NUM_BIT-1:0] in_index,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [P_SIZE-1:0]      out_max,
    output logic [POS_NUM_BIT-1:0] out_index,
    output logic [CNT_BITS-1:0]    out_count,
    output logic                   out_trunc
);

    // State encoding
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [CNT_BITS-1:0] c_max_len = CNT_BITS'(MAX_LEN);
    localparam logic [CNT_BITS-1:0] c_one     = CNT_BITS'(1);

    logic [1:0]             r_state;
    logic [P_SIZE-1:0]      r_best_max;
    logic [POS_NUM_BIT-1:0] r_best_index;
    logic [CNT_BITS-1:0]    r_count;
    logic                   r_trunc;

    logic                   w_gt;
    logic [CNT_BITS-1:0]    w_count_next;
    logic                   w_close;

    // Candidate-versus-best comparison; only a strictly greater metric wins
`ifdef MAX_INDEX_SCAN_SIGNED_EN
    assign w_gt = $signed(in_data) > $signed(r_best_max);
`else
    assign w_gt = in_data > r_best_max;
`endif

    // Beat count after accepting the current beat: a fresh frame starts at 1
    assign w_count_next = (r_state == c_st_empty) ? c_one : (r_count + c_one);

    // A frame ends on its last beat or when it reaches the length limit
    assign w_close = in_last | (w_count_next == c_max_len);

    // Single-process FSM: state, running best, beat count and truncation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_empty;
            r_best_max   <= '0;
            r_best_index <= '0;
            r_count      <= '0;
            r_trunc      <= 1'b0;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (in_valid) begin
                        r_best_max   <= in_data;
                        r_best_index <= in_index;
                        r_count      <= w_count_next;
                        r_trunc      <= w_close & ~in_last;
                        r_state      <= w_close ? c_st_done : c_st_accum;
                    end
                end
                c_st_accum: begin
                    if (in_valid) begin
                        if (w_gt) begin
                            r_best_max   <= in_data;
                            r_best_index <= in_index;
                        end
                        r_count <= w_count_next;
                        r_trunc <= w_close & ~in_last;
                        if (w_close) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    // Result is held here; incoming beats are back-pressured
                    if (out_ready) begin
                        r_state <= c_st_empty;
                    end
                end
                default: begin
                    r_state <= c_st_empty;
                end
            endcase
        end
    end

    assign in_ready  = (r_state != c_st_done);
    assign out_valid = (r_state == c_st_done);
    assign out_max   = r_best_max;
    assign out_index = r_best_index;
    assign out_count = r_count;
    assign out_trunc = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_max_index_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_index_scan
// Brief    : Self-checking bench for max_index_scan (P_SIZE=8, MAX_LEN=4).
//            Directed scenarios followed by randomized frames checked against
//            a queue-based reference model of the arg-max rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_index_scan;

    localparam int P_SIZE      = 8;
    localparam int POS_NUM_BIT = 4;
    localparam int MAX_LEN     = 4;
    localparam int CNT_BITS    = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [P_SIZE-1:0]      in_data;
    logic [POS_NUM_BIT-1:0] in_index;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [P_SIZE-1:0]      out_max;
    logic [POS_NUM_BIT-1:0] out_index;
    logic [CNT_BITS-1:0]    out_count;
    logic                   out_trunc;

    max_index_scan #(
        .P_SIZE      (P_SIZE),
        .POS_NUM_BIT (POS_NUM_BIT),
        .MAX_LEN     (MAX_LEN),
        .CNT_BITS    (CNT_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_index  (in_index),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_index (out_index),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: beats of the frame in progress
    logic [P_SIZE-1:0]      q_data[$];
    logic [POS_NUM_BIT-1:0] q_idx[$];

    // Expected result of the most recently closed frame
    logic [P_SIZE-1:0]      exp_max;
    logic [POS_NUM_BIT-1:0] exp_index;
    int                     exp_count;
    logic                   exp_trunc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit beats(input logic [P_SIZE-1:0] a, input logic [P_SIZE-1:0] b);
`ifdef MAX_INDEX_SCAN_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Compute the winner of the modelled frame and compare the held result
    task automatic expect_result(input bit last_flag);
        exp_max   = q_data[0];
        exp_index = q_idx[0];
        for (int k = 1; k < q_data.size(); k++) begin
            if (beats(q_data[k], exp_max)) begin
                exp_max   = q_data[k];
                exp_index = q_idx[k];
            end
        end
        exp_count = q_data.size();
        exp_trunc = ~last_flag;
        check("res_valid", 32'(out_valid), 32'd1);
        check("res_in_ready", 32'(in_ready), 32'd0);
        check("res_max", 32'(out_max), 32'(exp_max));
        check("res_index", 32'(out_index), 32'(exp_index));
        check("res_count", 32'(out_count), 32'(exp_count));
        check("res_trunc", 32'(out_trunc), 32'(exp_trunc));
        q_data.delete();
        q_idx.delete();
    endtask

    // Hold the result for some cycles with junk input, then consume it
    task automatic drain(input int hold);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = P_SIZE'($urandom);
            in_index  = POS_NUM_BIT'($urandom);
            in_last   = 1'($urandom);
            step();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_max", 32'(out_max), 32'(exp_max));
            check("hold_index", 32'(out_index), 32'(exp_index));
            check("hold_count", 32'(out_count), 32'(exp_count));
            check("hold_trunc", 32'(out_trunc), 32'(exp_trunc));
        end
        // Beat offered during consumption must not be taken
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_last   = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
        step();
        check("drain_no_beat", 32'(out_valid), 32'd0);
    endtask

    // Offer one beat; when the model says the frame closes, check the result
    task automatic send(input logic [P_SIZE-1:0] d, input logic [POS_NUM_BIT-1:0] idx,
                        input bit last, input bit auto_drain, output bit closed);
        check("beat_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_index  = idx;
        in_last   = last;
        out_ready = 1'($urandom);
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        q_data.push_back(d);
        q_idx.push_back(idx);
        closed = last || (q_data.size() == MAX_LEN);
        if (closed) begin
            expect_result(last);
            if (auto_drain) drain($urandom_range(0, 3));
        end else begin
            check("mid_no_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        bit c;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_index  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_max", 32'(out_max), 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_trunc", 32'(out_trunc), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Scenario 1: 5/20/9/20(last), tie keeps index 1
        send(8'd5, 4'd0, 1'b0, 1'b1, c);
        send(8'd20, 4'd1, 1'b0, 1'b1, c);
        send(8'd9, 4'd2, 1'b0, 1'b1, c);
        send(8'd20, 4'd3, 1'b1, 1'b0, c);
        check("s1_max", 32'(out_max), 32'd20);
        check("s1_index", 32'(out_index), 32'd1);
        check("s1_count", 32'(out_count), 32'd4);
        check("s1_trunc", 32'(out_trunc), 32'd0);
        drain(1);

        // Scenario 2: single-beat frame
        send(8'h7F, 4'd6, 1'b1, 1'b0, c);
        check("s2_max", 32'(out_max), 32'h7F);
        check("s2_index", 32'(out_index), 32'd6);
        check("s2_count", 32'(out_count), 32'd1);
        drain(0);

        // Scenario 3: six beats without in_last; truncation at 4
        for (int b = 0; b < 4; b++) send(8'(10 + b), 4'(b), 1'b0, 1'b0, c);
        check("s3_trunc", 32'(out_trunc), 32'd1);
        check("s3_count", 32'(out_count), 32'd4);
        drain(0);
        send(8'd3, 4'd4, 1'b0, 1'b1, c);
        send(8'd1, 4'd5, 1'b0, 1'b1, c);
        send(8'd2, 4'd7, 1'b1, 1'b0, c);
        check("s3_new_count", 32'(out_count), 32'd3);
        drain(0);

        // Scenario 4: result held for 10 cycles
        send(8'd40, 4'd2, 1'b0, 1'b1, c);
        send(8'd90, 4'd9, 1'b1, 1'b0, c);
        drain(10);

        // Scenario 5: reset mid-frame, with a beat presented at the reset edge
        send(8'hEE, 4'd1, 1'b0, 1'b1, c);
        send(8'hDD, 4'd2, 1'b0, 1'b1, c);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        q_data.delete();
        q_idx.delete();
        check("s5_valid", 32'(out_valid), 32'd0);
        check("s5_count", 32'(out_count), 32'd0);
        check("s5_in_ready", 32'(in_ready), 32'd1);
        step();
        check("s5_still_idle", 32'(out_valid), 32'd0);
        send(8'd4, 4'd3, 1'b0, 1'b1, c);
        send(8'd8, 4'd5, 1'b1, 1'b0, c);
        check("s5_max", 32'(out_max), 32'd8);
        check("s5_count2", 32'(out_count), 32'd2);
        drain(0);

        // Scenario 6: sign-sensitive frame
        send(8'hF0, 4'd0, 1'b0, 1'b1, c);
        send(8'h05, 4'd1, 1'b1, 1'b0, c);
`ifdef MAX_INDEX_SCAN_SIGNED_EN
        check("s6_max", 32'(out_max), 32'h05);
        check("s6_index", 32'(out_index), 32'd1);
`else
        check("s6_max", 32'(out_max), 32'hF0);
        check("s6_index", 32'(out_index), 32'd0);
`endif
        drain(0);

        // Randomized frames, some longer than MAX_LEN, with bubbles and ties
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                logic [P_SIZE-1:0] d;
                if ($urandom_range(0, 3) == 0) step();
                d = ($urandom_range(0, 2) == 0) ? P_SIZE'($urandom_range(0, 3)) : P_SIZE'($urandom);
                send(d, POS_NUM_BIT'($urandom), (b == len - 1), 1'b1, c);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
